// File: rtl/stopwatch_core.sv
// rtl/stopwatch_core.sv - stopwatch time base: prescaler, BCD mm:ss counter, lap hold
module stopwatch_core #(
    parameter int DIV = 500_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] en,
    input  logic       lap,
    output logic       tick,
    output logic [3:0] sec_lo,
    output logic [2:0] sec_hi,
    output logic [3:0] min_lo,
    output logic [2:0] min_hi,
    output logic [3:0] disp_sec_lo,
    output logic [2:0] disp_sec_hi,
    output logic [3:0] disp_min_lo,
    output logic [2:0] disp_min_hi,
    output logic       lap_active,
    output logic       overflow
);

    localparam int PW = $clog2(DIV);
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    localparam logic [1:0] MODE_RUN   = 2'b01;
    localparam logic [1:0] MODE_PAUSE = 2'b10;

    logic [PW-1:0] presc;

    logic [3:0] hold_sec_lo;
    logic [2:0] hold_sec_hi;
    logic [3:0] hold_min_lo;
    logic [2:0] hold_min_hi;

    logic [3:0] nxt_sec_lo;
    logic [2:0] nxt_sec_hi;
    logic [3:0] nxt_min_lo;
    logic [2:0] nxt_min_hi;
    logic       nxt_wrap;

    logic second_due;
    logic counting;

    assign second_due = (presc == LAST);
    assign counting   = (en == MODE_RUN) || (en == MODE_PAUSE);

    // One-second BCD increment of the live time, rippling carries upward
    always_comb begin
        nxt_sec_lo = sec_lo;
        nxt_sec_hi = sec_hi;
        nxt_min_lo = min_lo;
        nxt_min_hi = min_hi;
        nxt_wrap   = 1'b0;
        if (sec_lo == 4'd9) begin
            nxt_sec_lo = 4'd0;
            if (sec_hi == 3'd5) begin
                nxt_sec_hi = 3'd0;
                if (min_lo == 4'd9) begin
                    nxt_min_lo = 4'd0;
                    if (min_hi == 3'd5) begin
                        nxt_min_hi = 3'd0;
                        nxt_wrap   = 1'b1;
                    end else begin
                        nxt_min_hi = min_hi + 3'd1;
                    end
                end else begin
                    nxt_min_lo = min_lo + 4'd1;
                end
            end else begin
                nxt_sec_hi = sec_hi + 3'd1;
            end
        end else begin
            nxt_sec_lo = sec_lo + 4'd1;
        end
    end

    // Prescaler, live time, tick and overflow; clear wins over a due increment
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc    <= '0;
            sec_lo   <= 4'd0;
            sec_hi   <= 3'd0;
            min_lo   <= 4'd0;
            min_hi   <= 3'd0;
            tick     <= 1'b0;
            overflow <= 1'b0;
        end else if (en == MODE_RUN) begin
            if (second_due) begin
                presc    <= '0;
                sec_lo   <= nxt_sec_lo;
                sec_hi   <= nxt_sec_hi;
                min_lo   <= nxt_min_lo;
                min_hi   <= nxt_min_hi;
                tick     <= 1'b1;
                overflow <= overflow | nxt_wrap;
            end else begin
                presc <= presc + 1'b1;
                tick  <= 1'b0;
            end
        end else if (en == MODE_PAUSE) begin
            tick <= 1'b0;
        end else begin
            presc    <= '0;
            sec_lo   <= 4'd0;
            sec_hi   <= 3'd0;
            min_lo   <= 4'd0;
            min_hi   <= 3'd0;
            tick     <= 1'b0;
            overflow <= 1'b0;
        end
    end

    // Lap hold: a pulse toggles the freeze; capture takes the pre-increment live value
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_sec_lo <= 4'd0;
            hold_sec_hi <= 3'd0;
            hold_min_lo <= 4'd0;
            hold_min_hi <= 3'd0;
            lap_active  <= 1'b0;
        end else if (counting) begin
            if (lap) begin
                if (!lap_active) begin
                    hold_sec_lo <= sec_lo;
                    hold_sec_hi <= sec_hi;
                    hold_min_lo <= min_lo;
                    hold_min_hi <= min_hi;
                    lap_active  <= 1'b1;
                end else begin
                    lap_active <= 1'b0;
                end
            end
        end else begin
            hold_sec_lo <= 4'd0;
            hold_sec_hi <= 3'd0;
            hold_min_lo <= 4'd0;
            hold_min_hi <= 3'd0;
            lap_active  <= 1'b0;
        end
    end

    // Display path follows live time unless a lap capture is being shown
    always_comb begin
        disp_sec_lo = sec_lo;
        disp_sec_hi = sec_hi;
        disp_min_lo = min_lo;
        disp_min_hi = min_hi;
        if (lap_active) begin
            disp_sec_lo = hold_sec_lo;
            disp_sec_hi = hold_sec_hi;
            disp_min_lo = hold_min_lo;
            disp_min_hi = hold_min_hi;
        end
    end

endmodule

// File: tb/tb_stopwatch_core.sv
// tb/tb_stopwatch_core.sv - self-checking bench for stopwatch_core
module tb_stopwatch_core;

    localparam int DIV = 4;

    logic       clk;
    logic       reset;
    logic [1:0] en;
    logic       lap;
    logic       tick;
    logic [3:0] sec_lo;
    logic [2:0] sec_hi;
    logic [3:0] min_lo;
    logic [2:0] min_hi;
    logic [3:0] disp_sec_lo;
    logic [2:0] disp_sec_hi;
    logic [3:0] disp_min_lo;
    logic [2:0] disp_min_hi;
    logic       lap_active;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    // reference model: elapsed whole seconds, cycles into the current second
    int m_cyc;
    int m_secs;
    int m_hold;
    bit m_tick;
    bit m_lapa;
    bit m_ovf;

    stopwatch_core #(.DIV(DIV)) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .lap         (lap),
        .tick        (tick),
        .sec_lo      (sec_lo),
        .sec_hi      (sec_hi),
        .min_lo      (min_lo),
        .min_hi      (min_hi),
        .disp_sec_lo (disp_sec_lo),
        .disp_sec_hi (disp_sec_hi),
        .disp_min_lo (disp_min_lo),
        .disp_min_hi (disp_min_hi),
        .lap_active  (lap_active),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cyc  = 0;
        m_secs = 0;
        m_hold = 0;
        m_tick = 0;
        m_lapa = 0;
        m_ovf  = 0;
    endtask

    task automatic model_step(input logic [1:0] e, input logic l);
        bit inc;
        inc = 0;
        if (e == 2'b01 || e == 2'b10) begin
            if (e == 2'b01) begin
                if (m_cyc == DIV - 1) begin
                    m_cyc = 0;
                    inc   = 1;
                end else begin
                    m_cyc++;
                end
            end
            if (l) begin
                if (!m_lapa) begin
                    m_hold = m_secs;
                    m_lapa = 1;
                end else begin
                    m_lapa = 0;
                end
            end
            if (inc) begin
                if (m_secs == 3599) m_ovf = 1;
                m_secs = (m_secs + 1) % 3600;
            end
            m_tick = inc;
        end else begin
            model_reset();
        end
    endtask

    task automatic check_all(input string where);
        int d;
        d = m_lapa ? m_hold : m_secs;
        chk({where, ".tick"},        8'(tick),        8'(m_tick));
        chk({where, ".sec_lo"},      8'(sec_lo),      8'((m_secs % 60) % 10));
        chk({where, ".sec_hi"},      8'(sec_hi),      8'((m_secs % 60) / 10));
        chk({where, ".min_lo"},      8'(min_lo),      8'((m_secs / 60) % 10));
        chk({where, ".min_hi"},      8'(min_hi),      8'(m_secs / 600));
        chk({where, ".disp_sec_lo"}, 8'(disp_sec_lo), 8'((d % 60) % 10));
        chk({where, ".disp_sec_hi"}, 8'(disp_sec_hi), 8'((d % 60) / 10));
        chk({where, ".disp_min_lo"}, 8'(disp_min_lo), 8'((d / 60) % 10));
        chk({where, ".disp_min_hi"}, 8'(disp_min_hi), 8'(d / 600));
        chk({where, ".lap_active"},  8'(lap_active),  8'(m_lapa));
        chk({where, ".overflow"},    8'(overflow),    8'(m_ovf));
    endtask

    // one rising edge with given inputs; inputs change 1 time unit after the edge
    task automatic cyc(input logic [1:0] e, input logic l, input string where, input bit do_chk);
        en  = e;
        lap = l;
        @(posedge clk);
        model_step(e, l);
        #1;
        if (do_chk) check_all(where);
    endtask

    initial begin
        logic [1:0] re;
        logic       rl;
        int         r;

        reset = 1'b0;
        en    = 2'b00;
        lap   = 1'b0;
        model_reset();
        #1;
        check_all("reset");
        #2 reset = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;

        // run from cleared state: first increment on edge DIV, then 00:10 and 01:00
        for (int i = 0; i < 240; i++) cyc(2'b01, 1'b0, "run", 1'b1);
        chk("run.240.min_lo", 8'(min_lo), 8'd1);
        chk("run.240.sec_lo", 8'(sec_lo), 8'd0);

        // asynchronous reset mid-run at 00:05, then held clear
        cyc(2'b00, 1'b0, "clr0", 1'b1);
        for (int i = 0; i < 20; i++) cyc(2'b01, 1'b0, "run5", 1'b1);
        chk("at5.sec_lo", 8'(sec_lo), 8'd5);
        #2 reset = 1'b0;
        model_reset();
        #1;
        check_all("async_reset");
        en = 2'b11;
        #1 reset = 1'b1;
        for (int i = 0; i < 10; i++) cyc(2'b11, 1'b0, "clear11", 1'b1);

        // pause preserves the partial second
        for (int i = 0; i < 6; i++)  cyc(2'b01, 1'b0, "pre_pause", 1'b1);
        for (int i = 0; i < 20; i++) cyc(2'b10, 1'b0, "pause", 1'b1);
        cyc(2'b01, 1'b0, "resume1", 1'b1);
        chk("resume1.sec_lo", 8'(sec_lo), 8'd1);
        cyc(2'b01, 1'b0, "resume2", 1'b1);
        chk("resume2.sec_lo", 8'(sec_lo), 8'd2);

        // wrap 59:59 -> 00:00 sets sticky overflow
        cyc(2'b00, 1'b0, "clr_wrap", 1'b1);
        for (int i = 0; i < 3599 * DIV; i++) cyc(2'b01, 1'b0, "to_5959", 1'b0);
        check_all("at_5959");
        chk("at_5959.min_hi", 8'(min_hi), 8'd5);
        for (int i = 0; i < 4; i++) cyc(2'b01, 1'b0, "wrap", 1'b1);
        chk("wrap.overflow", 8'(overflow), 8'd1);
        for (int i = 0; i < 4; i++) cyc(2'b01, 1'b0, "post_wrap", 1'b1);
        cyc(2'b00, 1'b0, "ovf_clear", 1'b1);

        // lap freeze at 00:07, release at 00:10
        for (int i = 0; i < 28; i++) cyc(2'b01, 1'b0, "to7", 1'b1);
        cyc(2'b01, 1'b1, "lap_on", 1'b1);
        chk("lap_on.disp_sec_lo", 8'(disp_sec_lo), 8'd7);
        for (int i = 0; i < 11; i++) cyc(2'b01, 1'b0, "lap_hold", 1'b1);
        chk("lap_hold.sec_hi", 8'(sec_hi), 8'd1);
        cyc(2'b01, 1'b1, "lap_off", 1'b1);
        chk("lap_off.disp_sec_hi", 8'(disp_sec_hi), 8'd1);

        // lap on the increment edge captures pre-increment value
        cyc(2'b00, 1'b0, "clr_lap", 1'b1);
        for (int i = 0; i < 15; i++) cyc(2'b01, 1'b0, "to3", 1'b1);
        cyc(2'b01, 1'b1, "lap_edge", 1'b1);
        chk("lap_edge.disp_sec_lo", 8'(disp_sec_lo), 8'd3);
        chk("lap_edge.sec_lo", 8'(sec_lo), 8'd4);
        cyc(2'b00, 1'b1, "lap_in_clear", 1'b1);
        cyc(2'b11, 1'b1, "lap_in_clear11", 1'b1);

        // randomized mode/lap traffic against the model
        for (int i = 0; i < 3000; i++) begin
            r  = int'($urandom_range(0, 19));
            re = (r < 14) ? 2'b01 : (r < 18) ? 2'b10 : (r == 18) ? 2'b00 : 2'b11;
            rl = ($urandom_range(0, 9) == 0);
            cyc(re, rl, "rand", 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
